// File: rtl/fft_sample_framer.sv
// fft_sample_framer: double-buffered 16-sample framer with clamping and FFT handshake.
// Ports: clk, reset (async, active-high); sample_in/sample_valid offer one sample per cycle;
// fft_done reports frame completion; t0..t15 hold the issued frame (t0 oldest);
// new_t strobes frame start; dropped strobes a discarded sample; frame_count counts frames mod 256.
module fft_sample_framer #(
    parameter int SAT_MAX = 511,
    parameter int SAT_MIN = -512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic        fft_done,
    output logic [15:0] t0,
    output logic [15:0] t1,
    output logic [15:0] t2,
    output logic [15:0] t3,
    output logic [15:0] t4,
    output logic [15:0] t5,
    output logic [15:0] t6,
    output logic [15:0] t7,
    output logic [15:0] t8,
    output logic [15:0] t9,
    output logic [15:0] t10,
    output logic [15:0] t11,
    output logic [15:0] t12,
    output logic [15:0] t13,
    output logic [15:0] t14,
    output logic [15:0] t15,
    output logic        new_t,
    output logic        dropped,
    output logic [7:0]  frame_count
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t      r_state;
    logic [15:0] r_buf [16];
    logic [15:0] r_t [16];
    logic [3:0]  r_wr_idx;
    logic        r_new_t;
    logic        r_dropped;
    logic [7:0]  r_frame_count;
    logic [15:0] w_clamped;
    logic        w_done;
    logic        w_free;
    logic        w_accept;
    logic        w_last;
    assign w_clamped = ($signed(sample_in) > SAT_MAX) ? 16'(SAT_MAX) :
                       ($signed(sample_in) < SAT_MIN) ? 16'(SAT_MIN) : sample_in;
    // A done level seen while new_t is high belongs to the previous frame.
    assign w_done   = fft_done && !r_new_t;
    assign w_free   = (r_state == IDLE) || (r_state == BUSY && w_done);
    assign w_accept = sample_valid && (r_state != HOLD);
    assign w_last   = w_accept && (r_wr_idx == 4'd15);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wr_idx      <= '0;
            r_new_t       <= 1'b0;
            r_dropped     <= 1'b0;
            r_frame_count <= '0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
                r_t[i]   <= '0;
            end
        end else begin
            r_new_t   <= 1'b0;
            r_dropped <= 1'b0;
            if (r_state == HOLD) begin
                if (w_done) begin
                    for (int i = 0; i < 16; i++) r_t[i] <= r_buf[i];
                    r_new_t       <= 1'b1;
                    r_frame_count <= r_frame_count + 8'd1;
                    r_state       <= BUSY;
                    // The buffer is free again, so a sample offered now starts the next frame.
                    if (sample_valid) begin
                        r_buf[0] <= w_clamped;
                        r_wr_idx <= 4'd1;
                    end else begin
                        r_wr_idx <= 4'd0;
                    end
                end else begin
                    r_dropped <= sample_valid;
                end
            end else begin
                if (w_accept) begin
                    r_buf[r_wr_idx] <= w_clamped;
                    r_wr_idx        <= r_wr_idx + 4'd1;
                end
                if (w_last && w_free) begin
                    // Bypass the 16th sample straight into the output frame.
                    for (int i = 0; i < 15; i++) r_t[i] <= r_buf[i];
                    r_t[15]       <= w_clamped;
                    r_new_t       <= 1'b1;
                    r_frame_count <= r_frame_count + 8'd1;
                    r_state       <= BUSY;
                end else if (w_last) begin
                    r_state <= HOLD;
                end else if (r_state == BUSY && w_done) begin
                    r_state <= IDLE;
                end
            end
        end
    end
    assign t0          = r_t[0];
    assign t1          = r_t[1];
    assign t2          = r_t[2];
    assign t3          = r_t[3];
    assign t4          = r_t[4];
    assign t5          = r_t[5];
    assign t6          = r_t[6];
    assign t7          = r_t[7];
    assign t8          = r_t[8];
    assign t9          = r_t[9];
    assign t10         = r_t[10];
    assign t11         = r_t[11];
    assign t12         = r_t[12];
    assign t13         = r_t[13];
    assign t14         = r_t[14];
    assign t15         = r_t[15];
    assign new_t       = r_new_t;
    assign dropped     = r_dropped;
    assign frame_count = r_frame_count;
endmodule

// File: tb/tb_fft_sample_framer.sv
// tb_fft_sample_framer: randomized and directed bench against a queue-based frame model.
module tb_fft_sample_framer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        fft_done = 1'b0;
    logic [15:0] t [16];
    logic        new_t;
    logic        dropped;
    logic [7:0]  frame_count;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] m_cur [$];
    logic [15:0] m_wait [$];
    logic [15:0] m_frame [16];
    bit          m_busy;
    bit          m_new_t;
    bit          m_drop;
    int          m_count;

    always #5 clk = ~clk;

    fft_sample_framer dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .fft_done(fft_done),
        .t0(t[0]), .t1(t[1]), .t2(t[2]), .t3(t[3]), .t4(t[4]), .t5(t[5]), .t6(t[6]), .t7(t[7]),
        .t8(t[8]), .t9(t[9]), .t10(t[10]), .t11(t[11]), .t12(t[12]), .t13(t[13]), .t14(t[14]),
        .t15(t[15]), .new_t(new_t), .dropped(dropped), .frame_count(frame_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [15:0] clamp(input logic [15:0] s);
        int v;
        v = $signed(s);
        return v > 511 ? 16'd511 : v < -512 ? 16'hFE00 : s;
    endfunction

    task automatic model_clear();
        m_cur.delete();
        m_wait.delete();
        foreach (m_frame[i]) m_frame[i] = '0;
        m_busy = 0;
        m_new_t = 0;
        m_drop = 0;
        m_count = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_new_t"}, new_t, m_new_t);
        check({tag, "_dropped"}, dropped, m_drop);
        check({tag, "_frame_count"}, frame_count, m_count % 256);
        for (int i = 0; i < 16; i++) check($sformatf("%s_t%0d", tag, i), t[i], m_frame[i]);
    endtask

    // One clock: model the frame flow at the queue level, then compare after the edge.
    task automatic step(input bit v, input logic [15:0] s, input bit d);
        bit completes;
        @(negedge clk);
        sample_valid = v;
        sample_in = s;
        fft_done = d;
        completes = m_busy && d && !m_new_t;
        m_new_t = 0;
        m_drop = 0;
        if (m_wait.size() == 16) begin
            if (completes) begin
                foreach (m_frame[i]) m_frame[i] = m_wait[i];
                m_wait.delete();
                m_new_t = 1;
                m_count++;
                if (v) m_cur.push_back(clamp(s));
            end else begin
                m_drop = v;
            end
        end else begin
            if (v) m_cur.push_back(clamp(s));
            if (m_cur.size() == 16) begin
                if (!m_busy || completes) begin
                    foreach (m_frame[i]) m_frame[i] = m_cur[i];
                    m_new_t = 1;
                    m_count++;
                    m_busy = 1;
                end else begin
                    m_wait = m_cur;
                end
                m_cur.delete();
            end else if (completes) begin
                m_busy = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs("step");
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        sample_valid = 0;
        fft_done = 0;
        #2 reset = 1;
        #1;
        model_clear();
        check_outputs(tag);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        model_clear();
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset = 0;
        for (int i = 1; i <= 16; i++) step(1, 16'(i), 0);
        check("basic_new_t", new_t, 1);
        check("basic_fc", frame_count, 1);
        for (int i = 0; i < 16; i++) check($sformatf("basic_t%0d", i), t[i], i + 1);
        step(0, 0, 0);
        check("basic_new_t_once", new_t, 0);
        step(0, 0, 1);
        step(1, 16'(600), 0);
        step(1, 16'(-700), 0);
        step(1, 16'(511), 0);
        step(1, 16'(-512), 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        check("clamp_t0", t[0], 511);
        check("clamp_t1", t[1], 16'hFE00);
        check("clamp_t2", t[2], 511);
        check("clamp_t3", t[3], 16'hFE00);
        check("clamp_t4", t[4], 0);
        apply_reset("reset_b2b");
        for (int i = 1; i <= 32; i++) step(1, 16'(i), 0);
        for (int i = 33; i <= 35; i++) begin
            step(1, 16'(i), 0);
            check("b2b_dropped", dropped, 1);
        end
        step(0, 0, 1);
        check("b2b_new_t", new_t, 1);
        check("b2b_fc", frame_count, 2);
        for (int i = 0; i < 16; i++) check($sformatf("b2b_t%0d", i), t[i], i + 17);
        step(0, 0, 1);
        step(0, 0, 1);
        apply_reset("reset_sim");
        for (int i = 1; i <= 16; i++) step(1, 16'(i), 0);
        for (int i = 1; i <= 15; i++) step(1, 16'(100 + i), 0);
        step(1, 16'(116), 1);
        check("sim_new_t", new_t, 1);
        check("sim_dropped", dropped, 0);
        check("sim_fc", frame_count, 2);
        check("sim_t15", t[15], 116);
        apply_reset("reset_stale");
        for (int i = 1; i <= 48; i++) step(1, 16'(i), 1);
        check("stale_fc", frame_count, 3);
        check("stale_t0", t[0], 33);
        for (int i = 1; i <= 9; i++) step(1, 16'(200 + i), 0);
        @(negedge clk);
        sample_valid = 0;
        #2 reset = 1;
        #1;
        check("midrst_fc", frame_count, 0);
        check("midrst_t0", t[0], 0);
        check("midrst_t15", t[15], 0);
        check("midrst_new_t", new_t, 0);
        check("midrst_dropped", dropped, 0);
        model_clear();
        @(negedge clk);
        reset = 0;
        for (int i = 1; i <= 16; i++) step(1, 16'(300 + i), 0);
        check("midrst_frame_fc", frame_count, 1);
        check("midrst_frame_t0", t[0], 301);
        check("midrst_frame_t15", t[15], 316);
        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 2);
        apply_reset("reset_wrap");
        for (int n = 0; n < 4130; n++) step(1, 16'($urandom), 1);
        check("wrap_fc", frame_count, m_count % 256);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fft_sample_framer.md
FFT_SAMPLE_FRAMER -- requirements
Module: fft_sample_framer

Interface
REQ-001 SHALL have parameter SAT_MAX, default 511: upper clamp bound for stored samples.
REQ-002 SHALL have parameter SAT_MIN, default -512: lower clamp bound for stored samples.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sample_in, input, 16, signed two's-complement audio sample.
REQ-006 SHALL have port sample_valid, input, 1, sample_in is offered this cycle.
REQ-007 SHALL have port fft_done, input, 1, the downstream FFT has finished the current frame.
REQ-008 SHALL have ports t0..t15, output, 16 each, registered frame to the FFT; t0 is the oldest sample.
REQ-009 SHALL have port new_t, output, 1, registered one-cycle frame-start strobe to the FFT.
REQ-010 SHALL have port dropped, output, 1, registered one-cycle strobe: an offered sample was discarded.
REQ-011 SHALL have port frame_count, output, 8, number of frames issued, modulo 256.

Function
REQ-012 SHALL keep a 16-entry write buffer and a 4-bit write index wr_idx, separate from the t0..t15 output registers (double buffering).
REQ-013 SHALL clamp each accepted sample to [SAT_MIN, SAT_MAX] before storing: values above become 511, below become -512, sign-extended to 16 bits.
REQ-014 SHALL use a three-state machine: IDLE (no frame at FFT), BUSY (frame issued, awaiting fft_done), HOLD (write buffer full while BUSY).
REQ-015 SHALL, in IDLE or BUSY, accept a sample whenever sample_valid=1, store it at wr_idx and increment wr_idx.
REQ-016 SHALL define "FFT free" as: state IDLE, or state BUSY with fft_done=1 and new_t=0.
REQ-017 SHALL ignore fft_done while new_t=1, so a stale done level is never taken as completion.
REQ-018 SHALL, when the accepted sample has wr_idx=15 and the FFT is free, load t0..t15 from the buffer plus the new sample, set new_t=1 for the next cycle, increment frame_count, reset wr_idx to 0 and enter BUSY, all at that edge.
REQ-019 SHALL, when the accepted sample has wr_idx=15 and the FFT is not free, enter HOLD with the buffer full.
REQ-020 SHALL, in BUSY with fft_done=1 and new_t=0 and no frame completing, enter IDLE.
REQ-021 SHALL, in HOLD, discard every offered sample and pulse dropped for one cycle per discard, unless fft_done=1 in the same cycle.
REQ-022 SHALL, in HOLD with fft_done=1 and new_t=0, load t0..t15 from the buffer, pulse new_t, increment frame_count and enter BUSY with wr_idx=0; a sample offered in that same cycle SHALL be accepted as index 0 and not flagged as dropped.
REQ-023 SHALL keep t0..t15 stable from new_t until the next frame load.
REQ-024 SHALL wrap frame_count from 255 to 0 without any flag.
REQ-025 SHALL keep new_t and dropped low in every cycle not specified above.

Reset
REQ-026 SHALL, while reset=1, asynchronously force state IDLE, wr_idx=0, t0..t15=0, buffer=0, new_t=0, dropped=0, frame_count=0.
REQ-027 SHALL, when reset is asserted mid-frame or in BUSY/HOLD, discard partial and pending frames; after release, the first accepted sample is index 0.

Verification
REQ-028 SHALL verify a basic frame: reset, then 16 valid samples 1..16 in IDLE -> one cycle after the 16th edge, new_t=1 for exactly 1 cycle, t0=1 ... t15=16, frame_count=1.
REQ-029 SHALL verify clamping: samples 600, -700, 511, -512, 0 in slots 0..4 -> t0=511, t1=-512, t2=511, t3=-512, t4=0.
REQ-030 SHALL verify back-to-back frames: 32 continuous samples, fft_done held low -> first frame issued; after the 32nd sample the state is HOLD; 3 more samples -> 3 dropped pulses; fft_done=1 -> second frame issued with samples 17..32 and frame_count=2.
REQ-031 SHALL verify a simultaneous event: in BUSY, 16th sample accepted in the same cycle as fft_done=1 -> immediate new_t, no HOLD entry, no dropped pulse.
REQ-032 SHALL verify a stale done: fft_done held at 1 continuously -> the first new_t cycle is ignored, completion is recognised only on the following cycle, and no frame is lost.
REQ-033 SHALL verify reset mid-operation: reset asserted after 9 samples, with no clock edge -> all outputs 0 immediately; 16 new samples after release give exactly one frame containing only the new samples.
